// File: rtl/mem_arbiter_pkg.sv
// Shared types for the unified-memory arbiter of the RV16I core.
//   state_t     : arbiter FSM states
//   owner_t     : which requester owns the in-flight transaction
//   mem_req_t   : latched memory command (we, addr, wdata)
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Handshake bundle between the core's fetch/data ports, the arbiter and the
// memory macro / bus bridge.
//   slave  : arbiter side (takes requests and memory responses, drives
//            grants, responses and the memory command)
//   master : environment side (core requesters plus memory)
interface mem_arbiter_if;

  // fetch port
  logic        if_req_i;
  logic [15:0] if_addr_i;
  logic        if_gnt_o;
  logic        if_rvalid_o;

  // data port
  logic        d_req_i;
  logic        d_we_i;
  logic [15:0] d_addr_i;
  logic [15:0] d_wdata_i;
  logic        d_gnt_o;
  logic        d_rvalid_o;

  // shared response
  logic [15:0] rdata_o;
  logic        err_o;

  // memory side
  logic        mem_req_o;
  logic        mem_we_o;
  logic [15:0] mem_addr_o;
  logic [15:0] mem_wdata_o;
  logic        mem_rvalid_i;
  logic [15:0] mem_rdata_i;

  modport slave (
    input  if_req_i, if_addr_i,
    input  d_req_i, d_we_i, d_addr_i, d_wdata_i,
    input  mem_rvalid_i, mem_rdata_i,
    output if_gnt_o, if_rvalid_o,
    output d_gnt_o, d_rvalid_o,
    output rdata_o, err_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output if_req_i, if_addr_i,
    output d_req_i, d_we_i, d_addr_i, d_wdata_i,
    output mem_rvalid_i, mem_rdata_i,
    input  if_gnt_o, if_rvalid_o,
    input  d_gnt_o, d_rvalid_o,
    input  rdata_o, err_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

endinterface

// File: rtl/arb_starve_ctr.sv
// Saturating up-counter tracking consecutive data grants taken while fetch
// was waiting.
//   clk, rst_n : clock, synchronous active-low reset
//   inc        : count one more data grant (ignored once saturated)
//   clr        : return to zero (wins over inc)
//   sat        : count has reached MAX
module arb_starve_ctr
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam int unsigned CW = $clog2(MAX + 1);

  logic [CW-1:0] cnt;

  assign sat = (cnt == CW'(MAX));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !sat) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-ported 16-bit memory between instruction fetch
// and the MEM/WB data stage. Data has fixed priority, except that fetch wins
// once data has been granted STARVE_MAX times in a row while fetch waited.
// A transaction whose memory response does not arrive within TIMEOUT ISSUE
// cycles is completed with err_o=1 and rdata_o=0.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : mem_arbiter_if.slave
//                if_* : fetch req/addr in, gnt/rvalid out
//                d_*  : data req/we/addr/wdata in, gnt/rvalid out
//                rdata_o/err_o : shared response, valid with either rvalid
//                mem_* : memory command out (held until mem_rvalid_i),
//                        response/read data in
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_arbiter_if.slave bus
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  state_t        state;
  owner_t        owner;
  mem_req_t      req_q;
  logic [TW-1:0] tmo_cnt;
  logic          mem_req_q;
  logic          if_rvalid_q;
  logic          d_rvalid_q;
  logic [15:0]   rdata_q;
  logic          err_q;

  logic          starve_sat;
  logic          starve_inc;
  logic          starve_clr;
  logic          pick_if;
  logic          pick_d;

  // Grants are combinational in IDLE; gated by rst_n so no grant is ever
  // seen for a cycle whose state update is being discarded by reset.
  always_comb begin
    pick_if = 1'b0;
    pick_d  = 1'b0;
    if (rst_n && state == IDLE) begin
      if (bus.d_req_i && !(starve_sat && bus.if_req_i)) begin
        pick_d = 1'b1;
      end else if (bus.if_req_i) begin
        pick_if = 1'b1;
      end
    end
  end

  assign starve_inc = pick_d && bus.if_req_i;
  assign starve_clr = pick_if || (state == IDLE && !bus.if_req_i);

  arb_starve_ctr #(
    .MAX (STARVE_MAX)
  ) u_starve_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (starve_inc),
    .clr   (starve_clr),
    .sat   (starve_sat)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      owner       <= OWN_IF;
      req_q       <= '0;
      tmo_cnt     <= '0;
      mem_req_q   <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pick_d || pick_if) begin
            if (pick_d) begin
              owner       <= OWN_D;
              req_q.we    <= bus.d_we_i;
              req_q.addr  <= bus.d_addr_i;
              req_q.wdata <= bus.d_wdata_i;
            end else begin
              owner       <= OWN_IF;
              req_q.we    <= 1'b0;
              req_q.addr  <= bus.if_addr_i;
              req_q.wdata <= '0;
            end
            tmo_cnt   <= '0;
            mem_req_q <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.mem_rvalid_i || tmo_cnt == TW'(TIMEOUT - 1)) begin
            // Write acks and timeouts both return zero data.
            rdata_q     <= (bus.mem_rvalid_i && !req_q.we) ? bus.mem_rdata_i : '0;
            err_q       <= !bus.mem_rvalid_i;
            tmo_cnt     <= '0;
            mem_req_q   <= 1'b0;
            if_rvalid_q <= (owner == OWN_IF);
            d_rvalid_q  <= (owner == OWN_D);
            state       <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.if_gnt_o    = pick_if;
  assign bus.d_gnt_o     = pick_d;
  assign bus.if_rvalid_o = if_rvalid_q;
  assign bus.d_rvalid_o  = d_rvalid_q;
  assign bus.rdata_o     = rdata_q;
  assign bus.err_o       = err_q;
  assign bus.mem_req_o   = mem_req_q;
  assign bus.mem_we_o    = req_q.we;
  assign bus.mem_addr_o  = req_q.addr;
  assign bus.mem_wdata_o = req_q.wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes the expected response
// (owner, data, error, arrival cycle) on each grant; a monitor pops and
// compares whenever an rvalid is seen. A behavioural memory with adjustable
// latency answers mem_req_o.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_arbiter_if bus ();

  mem_arbiter #(
    .STARVE_MAX (4),
    .TIMEOUT    (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    bit          is_d;
    logic [15:0] rdata;
    bit          err;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input bit is_d, input logic [15:0] rdata, input bit err, input int due);
    exp_t e;
    e.is_d  = is_d;
    e.rdata = rdata;
    e.err   = err;
    e.due   = due;
    sb.push_back(e);
  endtask

  // ---------------- memory model ----------------
  logic [15:0] mem [0:2047];
  int          mem_lat  = 0;
  bit          mem_mute = 0;
  int          kick_req = 0;

  initial begin
    int wait_cnt = 0;
    int kick_done = 0;
    for (int i = 0; i < 2048; i++) mem[i] = 16'h0000;
    mem[16'h0010 >> 1] = 16'hA5A5;
    mem[16'h0100 >> 1] = 16'h5A01;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = 16'hBEEF;
    forever begin
      @(posedge clk);
      #1;
      bus.mem_rvalid_i = 1'b0;
      bus.mem_rdata_i  = 16'hBEEF;
      if (kick_req != kick_done) begin
        kick_done = kick_req;
        bus.mem_rvalid_i = 1'b1;
      end else if (bus.mem_req_o && !mem_mute) begin
        if (wait_cnt >= mem_lat) begin
          wait_cnt = 0;
          bus.mem_rvalid_i = 1'b1;
          if (bus.mem_we_o) begin
            mem[bus.mem_addr_o[11:1]] = bus.mem_wdata_o;
            bus.mem_rdata_i = 16'hDEAD;
          end else begin
            bus.mem_rdata_i = mem[bus.mem_addr_o[11:1]];
          end
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // ---------------- response monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.if_gnt_o || bus.d_gnt_o)
        chk("gnt_exclusive", {bus.if_gnt_o, bus.d_gnt_o} == 2'b11, 0);
      if (bus.if_rvalid_o || bus.d_rvalid_o) begin
        chk("rvalid_exclusive", {bus.if_rvalid_o, bus.d_rvalid_o} == 2'b11, 0);
        if (sb.size() == 0) begin
          chk("unexpected_rvalid", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("rsp_owner_is_d", bus.d_rvalid_o, e.is_d);
          chk("rsp_rdata", bus.rdata_o, e.rdata);
          chk("rsp_err", bus.err_o, e.err);
          chk("rsp_cycle", cyc, e.due);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_gnt(output int who);
    who = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.d_gnt_o) begin who = 2; break; end
      if (bus.if_gnt_o) begin who = 1; break; end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic quiet(input string name, input int n);
    bit seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.if_rvalid_o || bus.d_rvalid_o) seen = 1;
    end
    chk(name, seen, 0);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_ctrl"}, {bus.if_gnt_o, bus.if_rvalid_o, bus.d_gnt_o, bus.d_rvalid_o,
                          bus.err_o, bus.mem_req_o, bus.mem_we_o}, 0);
    chk({name, "_data"}, {bus.rdata_o, bus.mem_addr_o, bus.mem_wdata_o}, 0);
  endtask

  initial begin
    int who;
    int t0;
    int n;
    bit ok;

    rst_n = 1'b0;
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 16'h0010;
    bus.d_req_i   = 1'b1;
    bus.d_we_i    = 1'b0;
    bus.d_addr_i  = 16'h0100;
    bus.d_wdata_i = 16'h0000;

    // reset state, with requests pending that must not be granted
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk);
    #1;
    bus.if_req_i = 1'b0;
    bus.d_req_i  = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // single fetch, memory answers 2 cycles after mem_req_o
    mem_lat = 2;
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 16'h0010;
    wait_gnt(who);
    chk("fetch_gnt", who, 1);
    push(0, 16'hA5A5, 0, cyc + 4);
    @(posedge clk);
    #1;
    bus.if_req_i  = 1'b0;
    bus.if_addr_i = 16'hFFFF;
    @(negedge clk);
    chk("fetch_mem_cmd", {bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o}, {1'b1, 1'b0, 16'h0010});
    drain();

    // simultaneous requests: data first, fetch in the IDLE after d_rvalid
    mem_lat = 0;
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 16'h0010;
    bus.d_req_i   = 1'b1;
    bus.d_we_i    = 1'b0;
    bus.d_addr_i  = 16'h0100;
    wait_gnt(who);
    chk("simul_first_d", who, 2);
    t0 = cyc;
    push(1, 16'h5A01, 0, cyc + 2);
    @(posedge clk);
    #1;
    bus.d_req_i = 1'b0;
    wait_gnt(who);
    chk("simul_then_if", who, 1);
    chk("simul_if_delay", cyc - t0, 3);
    push(0, 16'hA5A5, 0, cyc + 2);
    @(posedge clk);
    #1;
    bus.if_req_i = 1'b0;
    drain();

    // starvation: expected grant pattern d d d d F d d d d F
    mem_lat = 0;
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 16'h0010;
    bus.d_req_i   = 1'b1;
    bus.d_we_i    = 1'b0;
    bus.d_addr_i  = 16'h0100;
    for (int k = 0; k < 10; k++) begin
      wait_gnt(who);
      chk($sformatf("starve_grant%0d", k), who, (k % 5 == 4) ? 1 : 2);
      if (who == 2) push(1, 16'h5A01, 0, cyc + 2);
      if (who == 1) begin
        push(0, 16'hA5A5, 0, cyc + 2);
        @(posedge clk);
        #1;
        bus.if_req_i = 1'b0;
        if (k == 9) bus.d_req_i = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        bus.if_req_i = (k != 9);
      end
    end
    @(posedge clk);
    #1;
    bus.if_req_i = 1'b0;
    bus.d_req_i  = 1'b0;
    drain();

    // write: command latched at grant, stable through ISSUE
    mem_lat = 1;
    bus.d_req_i   = 1'b1;
    bus.d_we_i    = 1'b1;
    bus.d_addr_i  = 16'h0200;
    bus.d_wdata_i = 16'h1234;
    wait_gnt(who);
    chk("wr_gnt", who, 2);
    push(1, 16'h0000, 0, cyc + 3);
    @(posedge clk);
    #1;
    bus.d_req_i   = 1'b0;
    bus.d_we_i    = 1'b0;
    bus.d_addr_i  = 16'hFFFE;
    bus.d_wdata_i = 16'hFFFF;
    n = 0;
    ok = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!bus.mem_req_o) break;
      n++;
      if ({bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o} !== {1'b1, 16'h0200, 16'h1234}) ok = 0;
    end
    chk("wr_cmd_stable", ok, 1);
    chk("wr_issue_cycles", n, 2);
    drain();

    // read back the written word
    mem_lat = 0;
    bus.d_req_i  = 1'b1;
    bus.d_we_i   = 1'b0;
    bus.d_addr_i = 16'h0200;
    wait_gnt(who);
    chk("rdback_gnt", who, 2);
    push(1, 16'h1234, 0, cyc + 2);
    @(posedge clk);
    #1;
    bus.d_req_i = 1'b0;
    drain();

    // timeout: memory silent, then a late response that must be ignored
    mem_mute = 1;
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 16'h0010;
    wait_gnt(who);
    chk("tmo_gnt", who, 1);
    push(0, 16'h0000, 1, cyc + 17);
    @(posedge clk);
    #1;
    bus.if_req_i = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!bus.mem_req_o) break;
      n++;
    end
    chk("tmo_issue_cycles", n, 16);
    kick_req++;
    quiet("tmo_late_ignored", 6);
    mem_mute = 0;
    drain();

    // reset in the middle of ISSUE
    mem_lat = 5;
    bus.d_req_i  = 1'b1;
    bus.d_we_i   = 1'b0;
    bus.d_addr_i = 16'h0100;
    wait_gnt(who);
    chk("rst_mid_gnt", who, 2);
    @(posedge clk);
    #1;
    bus.d_req_i = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk_all_zero("rst_mid");
    quiet("rst_mid_dropped", 10);
    @(posedge clk);
    #1;
    mem_lat = 0;
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 16'h0010;
    wait_gnt(who);
    chk("post_rst_gnt", who, 1);
    push(0, 16'hA5A5, 0, cyc + 2);
    @(posedge clk);
    #1;
    bus.if_req_i = 1'b0;
    drain();

    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-ported 16-bit unified memory between two requesters of the RV16I 3-stage core: instruction fetch (IF port) and the MEM/WB data stage (D port).
- Serialises requests with a req/gnt/rvalid handshake. Data has fixed priority over fetch, bounded by an anti-starvation counter.
- A per-transaction timeout protects the core from a memory that never responds.
- Sits between the core's fetch/dmem interfaces and the memory macro or bus bridge.

Parameters:
- STARVE_MAX, 4: consecutive data grants allowed while if_req_i is pending before fetch is forced to win.
- TIMEOUT, 16: cycles in ISSUE without mem_rvalid_i before the transaction is aborted with an error.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- if_req_i  in  1  fetch request
- if_addr_i  in  16  fetch byte address
- if_gnt_o  out  1  fetch request accepted (1-cycle pulse)
- if_rvalid_o  out  1  fetch response valid (1-cycle pulse)
- d_req_i  in  1  data request
- d_we_i  in  1  data write (1) / read (0)
- d_addr_i  in  16  data byte address
- d_wdata_i  in  16  data write data
- d_gnt_o  out  1  data request accepted (1-cycle pulse)
- d_rvalid_o  out  1  data response valid; read data or write ack (1-cycle pulse)
- rdata_o  out  16  response data, shared, valid with either rvalid
- err_o  out  1  response is a timeout error, valid with either rvalid
- mem_req_o  out  1  memory request, held until mem_rvalid_i
- mem_we_o  out  1  memory write
- mem_addr_o  out  16  memory address
- mem_wdata_o  out  16  memory write data
- mem_rvalid_i  in  1  memory response / ack
- mem_rdata_i  in  16  memory read data

Behaviour:
- Reset: all outputs are 0; FSM is in IDLE; starvation and timeout counters are 0; owner is cleared.
- FSM states: IDLE, ISSUE, RESP.
- IDLE: arbitrates among requests present in the cycle.
  - Data wins if d_req_i=1, unless the starvation count equals STARVE_MAX and if_req_i=1, in which case fetch wins.
  - The winner gets a combinational gnt pulse in the same cycle. Its we/addr/wdata are latched on that edge (fetch latches we=0). Owner is recorded. Next state is ISSUE.
  - mem_rvalid_i is ignored in IDLE.
- Starvation counter:
  - Increments on each data grant while if_req_i=1.
  - Clears on any fetch grant, or on an arbitration cycle with if_req_i=0.
  - Saturates at STARVE_MAX.
- ISSUE:
  - mem_req_o=1, with mem_we/addr/wdata driven from registers, stable for the whole state.
  - The timeout counter increments each cycle.
  - mem_rvalid_i=1: latch mem_rdata_i, err=0, go to RESP. The counter clears.
  - Counter reaches TIMEOUT-1 without mem_rvalid_i: rdata=0, err=1, go to RESP. A late mem_rvalid_i is then ignored.
- RESP:
  - Exactly one of if_rvalid_o/d_rvalid_o (per owner) is 1 for one cycle, with registered rdata_o/err_o. mem_req_o=0.
  - Next state is IDLE. No arbitration happens in RESP.
- Throughput and latency:
  - Minimum 3 cycles per transaction: grant, one ISSUE cycle, RESP.
  - Grant-to-rvalid latency is memory latency + 2.
- Requester rules:
  - req/addr/we/wdata must stay stable until gnt. They may change the cycle after gnt.
  - A requester must not issue a new request before its rvalid.
  - gnt is never given while not in IDLE.
- Simultaneous requests: exactly one gnt per IDLE cycle. Both gnt outputs are never 1 together. Both rvalid outputs are never 1 together.
- Writes: memory ack is returned as d_rvalid_o with rdata_o=don't-care (driven 0).
- Reset mid-transaction: the in-flight transaction is dropped with no rvalid. The FSM returns to IDLE and the counters clear.
- rdata_o/err_o hold their last value outside RESP. Verification checks them only when an rvalid is 1.

Decomposition:
- Shared package: FSM state enum (IDLE/ISSUE/RESP), owner enum (OWN_IF/OWN_D), and a memory request struct {we, addr[15:0], wdata[15:0]}.
- One sub-module, arb_starve_ctr: a saturating counter with inc/clr inputs and a sat output, used for the starvation count.
- The timeout counter is inline.

Test Plan:
- Single fetch: if_req_i=1, addr 0x0010; memory responds 2 cycles after mem_req_o with 0xA5A5 -> if_gnt_o in cycle 0, mem_addr_o=0x0010, if_rvalid_o=1 with rdata_o=0xA5A5, err_o=0 in cycle 4.
- Simultaneous requests: if_req_i and d_req_i both 1 (d read at 0x0100) -> d_gnt_o first; if_gnt_o only after d_rvalid_o, in the following IDLE cycle.
- Starvation: d_req_i held continuously with if_req_i=1, STARVE_MAX=4 -> 4 data grants, then the 5th grant goes to fetch; the counter clears afterwards.
- Write: d_we_i=1, addr 0x0200, wdata 0x1234 -> mem_we_o=1, mem_wdata_o=0x1234 stable through ISSUE; d_rvalid_o pulse after mem_rvalid_i.
- Timeout: mem_rvalid_i never asserted, TIMEOUT=16 -> owner rvalid with err_o=1, rdata_o=0 after 16 ISSUE cycles; a late mem_rvalid_i produces no extra rvalid.
- Reset in ISSUE: rst_n=0 for one cycle mid-transaction -> all outputs 0 next cycle; no rvalid for the dropped request; a new request is granted normally afterwards.
